// File: rtl/prediction_stat_tracker.sv
// Update-side bookkeeping for the SP/LHP/GHP prediction arbiter: queues each issued
// prediction triple, scores it on resolve, and keeps saturating stat counters and trends.
module prediction_stat_tracker #(
    parameter int STAT_COUNTER_WIDTH = 5,
    parameter int STAT_RESET_VALUE   = 8,
    parameter int FIFO_DEPTH         = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            pred_valid,
    output logic                            pred_ready,
    input  logic                            SP_pred,
    input  logic                            LHP_pred,
    input  logic                            GHP_pred,
    input  logic                            resolve_valid,
    input  logic                            resolve_taken,
    input  logic                            flush,
    output logic [STAT_COUNTER_WIDTH-1:0]   SP_stat_count,
    output logic [STAT_COUNTER_WIDTH-1:0]   LHP_stat_count,
    output logic [STAT_COUNTER_WIDTH-1:0]   GHP_stat_count,
    output logic [3:0]                      SP_trend_decode,
    output logic [3:0]                      LHP_trend_decode,
    output logic [3:0]                      GHP_trend_decode,
    output logic                            resolve_error,
    output logic [$clog2(FIFO_DEPTH):0]     outstanding
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int OCC_W   = PTR_W + 1;
    localparam int CNT_W   = STAT_COUNTER_WIDTH;
    localparam int NPRED   = 3;
    localparam int SP_IDX  = 2;
    localparam int LHP_IDX = 1;
    localparam int GHP_IDX = 0;

    localparam logic [OCC_W-1:0] FULL_OCC  = OCC_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_RESET = CNT_W'(STAT_RESET_VALUE);
    localparam logic [1:0]       TREND_RESET = 2'b01;

    // Saturating increment on a hit, halving on a miss.
    function automatic logic [CNT_W-1:0] score_counter(input logic [CNT_W-1:0] cnt,
                                                      input logic hit);
        if (hit) begin
            return (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
        end
        return cnt >> 1;
    endfunction

    function automatic logic [3:0] trend_onehot(input logic [1:0] trend);
        return 4'b0001 << trend;
    endfunction

    // Entry layout {SP, LHP, GHP} so the bit index equals the predictor index.
    logic [NPRED-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [NPRED-1:0] head;
    logic [NPRED-1:0] correct;

    logic [CNT_W-1:0] stat_cnt  [NPRED];
    logic [1:0]       trend     [NPRED];
    logic [3:0]       trend_dec [NPRED];
    logic             err_q;

    assign full    = (occ == FULL_OCC);
    assign empty   = (occ == '0);
    assign push    = pred_valid && !full && !flush;
    assign pop     = resolve_valid && !empty;
    assign head    = fifo_mem[rd_ptr];
    assign correct = ~(head ^ {NPRED{resolve_taken}});

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {SP_pred, LHP_pred, GHP_pred};
        end
    end

    // Occupancy is kept apart from the pointers so full and empty never alias.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            occ <= occ + OCC_W'(push) - OCC_W'(pop);
        end
    end

    // Scoring still happens on a flush cycle: the head resolves before the rest is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NPRED; i++) begin
                stat_cnt[i]  <= CNT_RESET;
                trend[i]     <= TREND_RESET;
                trend_dec[i] <= trend_onehot(TREND_RESET);
            end
        end else if (pop) begin
            for (int i = 0; i < NPRED; i++) begin
                stat_cnt[i]  <= score_counter(stat_cnt[i], correct[i]);
                trend[i]     <= {trend[i][0], correct[i]};
                trend_dec[i] <= trend_onehot({trend[i][0], correct[i]});
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= resolve_valid && empty;
        end
    end

    assign pred_ready       = !full;
    assign outstanding      = occ;
    assign resolve_error    = err_q;
    assign SP_stat_count    = stat_cnt[SP_IDX];
    assign LHP_stat_count   = stat_cnt[LHP_IDX];
    assign GHP_stat_count   = stat_cnt[GHP_IDX];
    assign SP_trend_decode  = trend_dec[SP_IDX];
    assign LHP_trend_decode = trend_dec[LHP_IDX];
    assign GHP_trend_decode = trend_dec[GHP_IDX];

endmodule

// File: tb/tb_prediction_stat_tracker.sv
// Randomized and directed bench for prediction_stat_tracker against a queue-based model.
module tb_prediction_stat_tracker;

    localparam int W     = 5;
    localparam int DEPTH = 4;
    localparam int CMAX  = (1 << W) - 1;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           pred_valid = 1'b0;
    logic           pred_ready;
    logic           SP_pred = 1'b0;
    logic           LHP_pred = 1'b0;
    logic           GHP_pred = 1'b0;
    logic           resolve_valid = 1'b0;
    logic           resolve_taken = 1'b0;
    logic           flush = 1'b0;
    logic [W-1:0]   SP_stat_count, LHP_stat_count, GHP_stat_count;
    logic [3:0]     SP_trend_decode, LHP_trend_decode, GHP_trend_decode;
    logic           resolve_error;
    logic [2:0]     outstanding;

    prediction_stat_tracker #(
        .STAT_COUNTER_WIDTH(W),
        .STAT_RESET_VALUE(8),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .pred_valid(pred_valid), .pred_ready(pred_ready),
        .SP_pred(SP_pred), .LHP_pred(LHP_pred), .GHP_pred(GHP_pred),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken), .flush(flush),
        .SP_stat_count(SP_stat_count), .LHP_stat_count(LHP_stat_count),
        .GHP_stat_count(GHP_stat_count),
        .SP_trend_decode(SP_trend_decode), .LHP_trend_decode(LHP_trend_decode),
        .GHP_trend_decode(GHP_trend_decode),
        .resolve_error(resolve_error), .outstanding(outstanding)
    );

    always #5 clk = ~clk;

    // Index 2 = SP, 1 = LHP, 0 = GHP.
    logic [W-1:0] cnt_o [3];
    logic [3:0]   dec_o [3];
    assign cnt_o[2] = SP_stat_count;
    assign cnt_o[1] = LHP_stat_count;
    assign cnt_o[0] = GHP_stat_count;
    assign dec_o[2] = SP_trend_decode;
    assign dec_o[1] = LHP_trend_decode;
    assign dec_o[0] = GHP_trend_decode;

    int         n_checks = 0;
    int         n_pass   = 0;

    int         m_cnt   [3];
    int         m_trend [3];
    logic [2:0] m_q [$];
    bit         m_err;

    task automatic model_step(input bit pv, input logic [2:0] preds, input bit rv,
                              input bit rt, input bit fl, input bit rs);
        logic [2:0] e;
        bit can_push;
        bit hit;
        if (rs) begin
            for (int i = 0; i < 3; i++) begin
                m_cnt[i] = 8;
                m_trend[i] = 1;
            end
            m_q.delete();
            m_err = 0;
            return;
        end
        can_push = pv && (m_q.size() < DEPTH) && !fl;
        m_err = rv && (m_q.size() == 0);
        if (rv && m_q.size() > 0) begin
            e = m_q.pop_front();
            for (int i = 0; i < 3; i++) begin
                hit = (e[i] == rt);
                m_cnt[i] = hit ? ((m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX) : m_cnt[i] / 2;
                m_trend[i] = ((m_trend[i] * 2) + (hit ? 1 : 0)) % 4;
            end
        end
        if (fl) m_q.delete();
        else if (can_push) m_q.push_back(preds);
    endtask

    task automatic cyc(input bit pv, input logic [2:0] preds, input bit rv,
                       input bit rt, input bit fl, input bit rs);
        pred_valid = pv;
        {SP_pred, LHP_pred, GHP_pred} = preds;
        resolve_valid = rv;
        resolve_taken = rt;
        flush = fl;
        rst = rs;
        model_step(pv, preds, rv, rt, fl, rs);
        @(posedge clk);
        #1;
        pred_valid = 0; resolve_valid = 0; resolve_taken = 0; flush = 0; rst = 0;
        {SP_pred, LHP_pred, GHP_pred} = 3'b000;
    endtask

    task automatic test_reset();
        cyc(0, 3'b000, 0, 0, 0, 1);
        repeat (3) cyc(0, 3'b000, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (cnt_o[i] !== 5'd8) $display("FAIL reset_cnt[%0d] got %0d want 8", i, cnt_o[i]);
            else n_pass++;
            n_checks++;
            if (dec_o[i] !== 4'b0010) $display("FAIL reset_dec[%0d] got %b want 0010", i, dec_o[i]);
            else n_pass++;
        end
        n_checks++;
        if (pred_ready !== 1'b1 || outstanding !== 3'd0 || resolve_error !== 1'b0)
            $display("FAIL reset_ctrl got ready=%b occ=%0d err=%b want 1/0/0",
                     pred_ready, outstanding, resolve_error);
        else n_pass++;
    endtask

    task automatic test_basic();
        cyc(0, 3'b000, 0, 0, 0, 1);
        cyc(1, 3'b101, 0, 0, 0, 0);
        cyc(0, 3'b000, 1, 1, 0, 0);
        n_checks++;
        if (SP_stat_count !== 5'd9 || LHP_stat_count !== 5'd4 || GHP_stat_count !== 5'd9)
            $display("FAIL basic_cnt got %0d/%0d/%0d want 9/4/9",
                     SP_stat_count, LHP_stat_count, GHP_stat_count);
        else n_pass++;
        n_checks++;
        if (SP_trend_decode !== 4'b1000 || LHP_trend_decode !== 4'b0100 ||
            GHP_trend_decode !== 4'b1000)
            $display("FAIL basic_dec got %b/%b/%b want 1000/0100/1000",
                     SP_trend_decode, LHP_trend_decode, GHP_trend_decode);
        else n_pass++;
    endtask

    task automatic test_full();
        logic [2:0] ents [4] = '{3'b100, 3'b010, 3'b001, 3'b111};
        cyc(0, 3'b000, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) cyc(1, ents[i], 0, 0, 0, 0);
        n_checks++;
        if (pred_ready !== 1'b0 || outstanding !== 3'd4)
            $display("FAIL full_state got ready=%b occ=%0d want 0/4", pred_ready, outstanding);
        else n_pass++;
        cyc(1, 3'b000, 0, 0, 0, 0);
        n_checks++;
        if (outstanding !== 3'd4) $display("FAIL full_ignore got occ=%0d want 4", outstanding);
        else n_pass++;
        cyc(0, 3'b000, 1, 1, 0, 0);
        cyc(1, 3'b110, 0, 0, 0, 0);
        n_checks++;
        if (outstanding !== 3'd4 || pred_ready !== 1'b0)
            $display("FAIL full_refill got occ=%0d ready=%b want 4/0", outstanding, pred_ready);
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            cyc(0, 3'b000, 1, k[0], 0, 0);
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (cnt_o[i] !== W'(m_cnt[i]))
                    $display("FAIL full_order_cnt[%0d] step %0d got %0d want %0d",
                             i, k, cnt_o[i], m_cnt[i]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_saturation();
        cyc(0, 3'b000, 0, 0, 0, 1);
        for (int k = 0; k < 30; k++) begin
            cyc(1, 3'b101, 0, 0, 0, 0);
            cyc(0, 3'b000, 1, 1, 0, 0);
            n_checks++;
            if (SP_stat_count !== W'((8 + k + 1 > CMAX) ? CMAX : 8 + k + 1))
                $display("FAIL sat_sp step %0d got %0d", k, SP_stat_count);
            else n_pass++;
            n_checks++;
            if (LHP_stat_count !== W'(8 >> (k + 1)))
                $display("FAIL sat_lhp step %0d got %0d want %0d", k, LHP_stat_count, 8 >> (k + 1));
            else n_pass++;
        end
        n_checks++;
        if (SP_stat_count !== 5'd31 || LHP_trend_decode !== 4'b0001 || SP_trend_decode !== 4'b1000)
            $display("FAIL sat_final got sp=%0d lhp_dec=%b sp_dec=%b want 31/0001/1000",
                     SP_stat_count, LHP_trend_decode, SP_trend_decode);
        else n_pass++;
    endtask

    task automatic test_empty_resolve();
        cyc(0, 3'b000, 0, 0, 0, 1);
        cyc(0, 3'b000, 1, 1, 0, 0);
        n_checks++;
        if (resolve_error !== 1'b1 || SP_stat_count !== 5'd8 || LHP_stat_count !== 5'd8 ||
            GHP_stat_count !== 5'd8 || SP_trend_decode !== 4'b0010)
            $display("FAIL empty_err got err=%b cnt=%0d/%0d/%0d want 1 and 8s",
                     resolve_error, SP_stat_count, LHP_stat_count, GHP_stat_count);
        else n_pass++;
        cyc(0, 3'b000, 0, 0, 0, 0);
        n_checks++;
        if (resolve_error !== 1'b0) $display("FAIL empty_pulse got err=%b want 0", resolve_error);
        else n_pass++;
        cyc(1, 3'b011, 1, 0, 0, 0);
        n_checks++;
        if (resolve_error !== 1'b1 || outstanding !== 3'd1)
            $display("FAIL empty_push got err=%b occ=%0d want 1/1", resolve_error, outstanding);
        else n_pass++;
        cyc(0, 3'b000, 0, 0, 0, 0);
        n_checks++;
        if (resolve_error !== 1'b0) $display("FAIL empty_pulse2 got err=%b want 0", resolve_error);
        else n_pass++;
    endtask

    task automatic test_flush();
        cyc(0, 3'b000, 0, 0, 0, 1);
        cyc(1, 3'b110, 0, 0, 0, 0);
        cyc(1, 3'b000, 0, 0, 0, 0);
        cyc(1, 3'b111, 0, 0, 0, 0);
        cyc(1, 3'b101, 1, 0, 1, 0);
        n_checks++;
        if (outstanding !== 3'd0 || SP_stat_count !== 5'd4 || LHP_stat_count !== 5'd4 ||
            GHP_stat_count !== 5'd9)
            $display("FAIL flush_head got occ=%0d cnt=%0d/%0d/%0d want 0 4/4/9",
                     outstanding, SP_stat_count, LHP_stat_count, GHP_stat_count);
        else n_pass++;
        cyc(0, 3'b000, 1, 1, 0, 0);
        n_checks++;
        if (resolve_error !== 1'b1 || SP_stat_count !== 5'd4 || GHP_stat_count !== 5'd9)
            $display("FAIL flush_after got err=%b sp=%0d ghp=%0d want 1/4/9",
                     resolve_error, SP_stat_count, GHP_stat_count);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        cyc(0, 3'b000, 0, 0, 0, 1);
        cyc(1, 3'b001, 0, 0, 0, 0);
        cyc(1, 3'b010, 1, 0, 0, 0);
        cyc(1, 3'b100, 0, 0, 0, 0);
        cyc(1, 3'b111, 1, 1, 1, 1);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (cnt_o[i] !== 5'd8 || dec_o[i] !== 4'b0010)
                $display("FAIL midrst[%0d] got cnt=%0d dec=%b want 8/0010", i, cnt_o[i], dec_o[i]);
            else n_pass++;
        end
        n_checks++;
        if (outstanding !== 3'd0 || pred_ready !== 1'b1 || resolve_error !== 1'b0)
            $display("FAIL midrst_ctrl got occ=%0d ready=%b err=%b want 0/1/0",
                     outstanding, pred_ready, resolve_error);
        else n_pass++;
    endtask

    task automatic test_random();
        bit pv, rv, rt, fl, rs;
        logic [2:0] preds;
        cyc(0, 3'b000, 0, 0, 0, 1);
        for (int k = 0; k < 500; k++) begin
            pv = ($urandom_range(0, 99) < 55);
            rv = ($urandom_range(0, 99) < 45);
            rt = $urandom_range(0, 1);
            fl = ($urandom_range(0, 99) < 4);
            rs = ($urandom_range(0, 99) < 1);
            preds = 3'($urandom_range(0, 7));
            cyc(pv, preds, rv, rt, fl, rs);
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (cnt_o[i] !== W'(m_cnt[i]))
                    $display("FAIL rand_cnt[%0d] cyc %0d got %0d want %0d", i, k, cnt_o[i], m_cnt[i]);
                else n_pass++;
                n_checks++;
                if (dec_o[i] !== (4'b0001 << m_trend[i]))
                    $display("FAIL rand_dec[%0d] cyc %0d got %b want %b",
                             i, k, dec_o[i], 4'b0001 << m_trend[i]);
                else n_pass++;
            end
            n_checks++;
            if (outstanding !== 3'(m_q.size()) || pred_ready !== (m_q.size() < DEPTH) ||
                resolve_error !== m_err)
                $display("FAIL rand_ctrl cyc %0d got occ=%0d ready=%b err=%b want %0d/%b/%b",
                         k, outstanding, pred_ready, resolve_error,
                         m_q.size(), (m_q.size() < DEPTH), m_err);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_saturation();
        test_empty_resolve();
        test_flush();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/prediction_stat_tracker.md
Name: prediction_stat_tracker

Overview:
- Update-side counterpart of the three-way prediction arbiter, which combines the SP (static), LHP (local history) and GHP (global history) predictors.
- Records each predictor's individual prediction when the arbiter issues a branch prediction. Holds these records in-order in a small FIFO.
- On branch resolution, scores each predictor's correctness and maintains per-predictor saturating stat counters and 2-bit trend histories.
- Stat counts and one-hot trend decodes drive the arbiter's stat_count/trend_decode inputs directly.

Parameters:
- STAT_COUNTER_WIDTH, 5, width of each stat counter; must match the arbiter.
- STAT_RESET_VALUE, 8, counter value after reset.
- FIFO_DEPTH, 4, number of outstanding unresolved predictions; power of two, ≥2.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous reset, active-high.
- pred_valid  in  1  a prediction is issued this cycle.
- pred_ready  out  1  FIFO can accept; equals !full.
- SP_pred  in  1  SP prediction (1 = taken).
- LHP_pred  in  1  LHP prediction.
- GHP_pred  in  1  GHP prediction.
- resolve_valid  in  1  oldest outstanding branch resolves this cycle.
- resolve_taken  in  1  actual outcome.
- flush  in  1  discard all outstanding (wrong-path) records.
- SP_stat_count  out  STAT_COUNTER_WIDTH  registered counter.
- LHP_stat_count  out  STAT_COUNTER_WIDTH  registered counter.
- GHP_stat_count  out  STAT_COUNTER_WIDTH  registered counter.
- SP_trend_decode  out  4  one-hot decode of SP trend.
- LHP_trend_decode  out  4  one-hot decode of LHP trend.
- GHP_trend_decode  out  4  one-hot decode of GHP trend.
- resolve_error  out  1  one-cycle pulse: resolve_valid while FIFO empty.
- outstanding  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst=1 at edge):
  - All stat counters = STAT_RESET_VALUE.
  - All trends = 2'b01, so trend_decode = 4'b0010.
  - FIFO emptied; outstanding = 0; pred_ready = 1; resolve_error = 0.
  - Reset overrides every other input that cycle.
- FIFO entry is 3 bits {SP,LHP,GHP}. A push occurs when pred_valid && pred_ready && !flush.
- Push while full is impossible because pred_ready=0; pred_valid is ignored when full. There is no same-cycle bypass: a pop does not free a slot for a push in the same cycle.
- Pop occurs when resolve_valid && FIFO non-empty. Each predictor X is then scored as correct_X = (X_pred_head == resolve_taken).
- Counter update:
  - correct: +1, saturating at 2^STAT_COUNTER_WIDTH-1.
  - incorrect: logical right shift by 1 (halve); 0 stays 0.
- Trend update: trend_X <= {trend_X[0], correct_X}, where bit 0 is the newest result.
  - trend_decode = 1 << trend. Bit 0 means two consecutive misses; bit 3 means two consecutive hits.
- Latency: counters, trends and decodes change at the edge that samples the resolve and are visible the following cycle. Outputs are pure register outputs.
- resolve_valid with FIFO empty: no state change; resolve_error = 1 for the next cycle only.
- resolve_valid and pred_valid together on an empty FIFO: the resolve errors; the push is accepted.
- Push and pop in the same cycle on a non-empty, non-full FIFO: both happen; occupancy is unchanged.
- Flush:
  - At the edge, FIFO pointers and occupancy are cleared. Counters and trends are retained.
  - If resolve_valid is also high, the head is scored and updated first, then the remaining entries are discarded.
  - pred_valid during flush is dropped.
- Pointers wrap modulo FIFO_DEPTH. Occupancy is tracked separately, so full (== FIFO_DEPTH) and empty (== 0) are unambiguous.
- Input contract: resolves arrive in prediction order; the block does not reorder.

Test Plan:
- Reset, then idle 3 cycles -> all stat counts = 8, all trend_decode = 4'b0010, pred_ready = 1, outstanding = 0.
- Push {SP=1, LHP=0, GHP=1}, then resolve taken=1 -> SP=9, LHP=4, GHP=9; trends SP=11 (decode 1000), LHP=10 (0100), GHP=11 (1000).
- Push 4 entries without resolving -> pred_ready = 0 and outstanding = 4. A 5th pred_valid is ignored. One resolve, then push -> outstanding stays 4 and FIFO order is preserved.
- Resolve SP correctly 30 times -> SP stat saturates at 31 and does not wrap. LHP wrong repeatedly from 8: 4, 2, 1, 0, 0; LHP trend_decode = 0001.
- Resolve while empty -> counters unchanged, resolve_error high exactly one cycle. Repeat concurrently with pred_valid -> outstanding = 1.
- 3 outstanding entries, flush + resolve_valid in the same cycle -> head scored, outstanding = 0, following resolve flags resolve_error. Assert rst mid-stream with 2 outstanding -> full reset values the next cycle.
